pll_phase_ctrl: RTL and testbench

Sequencer for the ECP5 EHXPLLL clock generator. It drives the PLL reset and supervises lock with a stability filter. It releases the system reset to the SDRAM controller only after the lock has been stable for a set time. It also issues dynamic phase-step pulses (PHASESEL/PHASEDIR/PHASESTEP) on request, so the SDRAM capture clock (CLKOS) can be tuned at run time. It runs on the 25 MHz reference clock, which is never affected by PLL reset or phase stepping.

---
 rtl/pll_phase_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL sequencer: PLL reset, filtered lock supervision, system reset release, dynamic phase stepping.
// Optional build macro PLL_PHASE_CTRL_LOCK_TIMEOUT_EN re-resets the PLL when lock never arrives.
module pll_phase_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int STEP_LOW     = 2,
   parameter int STEP_GAP     = 4,
   parameter int PHASE_W      = 4
) (
   input  logic               clkin,
   input  logic               rst,
   input  logic               locked,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic [1:0]         phasesel,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg,
   input  logic               req_valid,
   input  logic [1:0]         req_sel,
   input  logic               req_dir,
   input  logic [3:0]         req_count,
   output logic               req_ready,
   output logic               busy,
   output logic [PHASE_W-1:0] phase_pos
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      READY     = 3'd3,
      SETUP     = 3'd4,
      STEP_LO   = 3'd5,
      STEP_HI   = 3'd6
   } state_t;

   localparam int M1      = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
   localparam int M2      = (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
   localparam int M3      = (M2 > STEP_LOW) ? M2 : STEP_LOW;
   localparam int CNT_MAX = (M3 > STEP_GAP) ? M3 : STEP_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           sync_q, sync_d;
   logic                 pll_rst_q, pll_rst_d;
   logic                 sys_rst_q, sys_rst_d;
   logic                 phasestep_q, phasestep_d;
   logic                 phasedir_q, phasedir_d;
   logic [1:0]           phasesel_q, phasesel_d;
   logic                 req_ready_q, req_ready_d;
   logic                 busy_q, busy_d;
   logic                 pend_q, pend_d;
   logic [3:0]           rem_q, rem_d;
   logic [PHASE_W-1:0]   pos_q, pos_d;
   logic                 lock_s;

   assign lock_s = sync_q[1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sync_d      = {sync_q[0], locked};
      pll_rst_d   = pll_rst_q;
      sys_rst_d   = sys_rst_q;
      phasestep_d = phasestep_q;
      phasedir_d  = phasedir_q;
      phasesel_d  = phasesel_q;
      req_ready_d = req_ready_q;
      busy_d      = busy_q;
      pend_d      = pend_q;
      rem_d       = rem_q;
      pos_d       = pos_q;

      case (state_q)
         RESET_PLL: begin
            pll_rst_d = 1'b1;
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d   = WAIT_LOCK;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end
`ifdef PLL_PHASE_CTRL_LOCK_TIMEOUT_EN
            else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d   = RESET_PLL;
               cnt_d     = '0;
               pll_rst_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
               state_d     = READY;
               cnt_d       = '0;
               sys_rst_d   = 1'b0;
               req_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            // Lock loss while released drops any request; completed steps stay in pos_q.
            if (!lock_s) begin
               state_d     = WAIT_LOCK;
               cnt_d       = '0;
               sys_rst_d   = 1'b1;
               phasestep_d = 1'b1;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
               pend_d      = 1'b0;
               phasesel_d  = 2'b00;
               phasedir_d  = 1'b1;
            end else begin
               case (state_q)
                  READY: begin
                     if (pend_q) begin
                        pend_d  = 1'b0;
                        state_d = SETUP;
                     end else if (!req_ready_q) begin
                        req_ready_d = 1'b1;
                        phasesel_d  = 2'b00;
                        phasedir_d  = 1'b1;
                     end else if (req_valid) begin
                        phasesel_d  = req_sel;
                        phasedir_d  = req_dir;
                        rem_d       = req_count;
                        req_ready_d = 1'b0;
                        if (req_count != 4'd0) begin
                           pend_d = 1'b1;
                           busy_d = 1'b1;
                        end
                     end
                  end
                  SETUP: begin
                     state_d     = STEP_LO;
                     cnt_d       = '0;
                     phasestep_d = 1'b0;
                  end
                  STEP_LO: begin
                     if (cnt_q == CNT_W'(STEP_LOW - 1)) begin
                        state_d     = STEP_HI;
                        cnt_d       = '0;
                        phasestep_d = 1'b1;
                        rem_d       = rem_q - 4'd1;
                        if (phasesel_q == 2'b00) begin
                           pos_d = phasedir_q ? pos_q - PHASE_W'(1) : pos_q + PHASE_W'(1);
                        end
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  STEP_HI: begin
                     if (cnt_q == CNT_W'(STEP_GAP - 1)) begin
                        cnt_d = '0;
                        if (rem_q != 4'd0) begin
                           state_d     = STEP_LO;
                           phasestep_d = 1'b0;
                        end else begin
                           state_d     = READY;
                           req_ready_d = 1'b1;
                           busy_d      = 1'b0;
                           phasesel_d  = 2'b00;
                           phasedir_d  = 1'b1;
                        end
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  default: begin
                     state_d = RESET_PLL;
                     cnt_d   = '0;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         sync_q      <= 2'b00;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         phasestep_q <= 1'b1;
         phasedir_q  <= 1'b1;
         phasesel_q  <= 2'b00;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         pend_q      <= 1'b0;
         rem_q       <= 4'd0;
         pos_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync_q      <= sync_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_q   <= sys_rst_d;
         phasestep_q <= phasestep_d;
         phasedir_q  <= phasedir_d;
         phasesel_q  <= phasesel_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         rem_q       <= rem_d;
         pos_q       <= pos_d;
      end
   end

   assign pll_rst      = pll_rst_q;
   assign sys_rst      = sys_rst_q;
   assign phasestep    = phasestep_q;
   assign phasedir     = phasedir_q;
   assign phasesel     = phasesel_q;
   assign phaseloadreg = 1'b1;
   assign req_ready    = req_ready_q;
   assign busy         = busy_q;
   assign phase_pos    = pos_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: power-up, lock glitch, step request table, lock loss, reset mid-step, timeout.
module tb_pll_phase_ctrl;

   logic       clk = 1'b0;
   logic       rst, locked, req_valid, req_dir;
   logic [1:0] req_sel;
   logic [3:0] req_count;
   logic       pll_rst, sys_rst, phasedir, phasestep, phaseloadreg, req_ready, busy;
   logic [1:0] phasesel;
   logic [3:0] phase_pos;

   logic       pll_rst_to, sys_rst_to, phasedir_to, phasestep_to, phaseloadreg_to, req_ready_to, busy_to;
   logic [1:0] phasesel_to;
   logic [3:0] phase_pos_to;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pll_phase_ctrl dut (
      .clkin(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst), .sys_rst(sys_rst),
      .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
      .req_valid(req_valid), .req_sel(req_sel), .req_dir(req_dir), .req_count(req_count),
      .req_ready(req_ready), .busy(busy), .phase_pos(phase_pos)
   );

   pll_phase_ctrl #(.LOCK_TIMEOUT(64)) dut_to (
      .clkin(clk), .rst(rst), .locked(1'b0), .pll_rst(pll_rst_to), .sys_rst(sys_rst_to),
      .phasesel(phasesel_to), .phasedir(phasedir_to), .phasestep(phasestep_to), .phaseloadreg(phaseloadreg_to),
      .req_valid(1'b0), .req_sel(2'b00), .req_dir(1'b0), .req_count(4'd0),
      .req_ready(req_ready_to), .busy(busy_to), .phase_pos(phase_pos_to)
   );

   typedef struct {
      logic [1:0] sel;
      logic       dir;
      logic [3:0] cnt;
      int         exp_pos;
      int         exp_dur;
      int         exp_lows;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
   endtask

   task automatic wait_release(input string name, input int exp_k);
      int rel = -1;
      for (int k = 1; k <= 1200; k++) begin
         tick();
         if (!sys_rst) begin
            rel = k;
            break;
         end
      end
      check(name, 32'(rel), 32'(exp_k));
      check({name, "_req_ready"}, 32'(req_ready), 1);
      check({name, "_busy"}, 32'(busy), 0);
   endtask

   task automatic issue(input logic [1:0] sel, input logic dir, input logic [3:0] cnt);
      int k = 0;
      while (!req_ready && k < 200) begin
         tick();
         k++;
      end
      check("wait_ready", 32'(req_ready), 1);
      req_valid = 1'b1;
      req_sel   = sel;
      req_dir   = dir;
      req_count = cnt;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      int r0, l0, l2, hi, hi_to, rises, rises_to, first_rise;
      int first_low, lows, dur;
      logic prev_to;

      vecs[0] = '{sel: 2'b00, dir: 1'b0, cnt: 4'd3,  exp_pos: 3,  exp_dur: 20, exp_lows: 6};
      vecs[1] = '{sel: 2'b00, dir: 1'b1, cnt: 4'd1,  exp_pos: 2,  exp_dur: 8,  exp_lows: 2};
      vecs[2] = '{sel: 2'b00, dir: 1'b1, cnt: 4'd5,  exp_pos: 13, exp_dur: 32, exp_lows: 10};
      vecs[3] = '{sel: 2'b01, dir: 1'b0, cnt: 4'd2,  exp_pos: 13, exp_dur: 14, exp_lows: 4};
      vecs[4] = '{sel: 2'b00, dir: 1'b0, cnt: 4'd0,  exp_pos: 13, exp_dur: 1,  exp_lows: 0};
      vecs[5] = '{sel: 2'b11, dir: 1'b1, cnt: 4'd1,  exp_pos: 13, exp_dur: 8,  exp_lows: 2};
      vecs[6] = '{sel: 2'b00, dir: 1'b0, cnt: 4'd15, exp_pos: 12, exp_dur: 92, exp_lows: 30};

      req_valid = 1'b0;
      req_sel   = 2'b00;
      req_dir   = 1'b0;
      req_count = 4'd0;
      locked    = 1'b0;

      // Power-up: reset values, pll_rst width, lock-to-release latency.
      rst = 1'b1;
      repeat (5) tick();
      check("rst_pll_rst", 32'(pll_rst), 1);
      check("rst_sys_rst", 32'(sys_rst), 1);
      check("rst_phasestep", 32'(phasestep), 1);
      check("rst_phasedir", 32'(phasedir), 1);
      check("rst_phaseloadreg", 32'(phaseloadreg), 1);
      check("rst_phasesel", 32'(phasesel), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_phase_pos", 32'(phase_pos), 0);
      rst = 1'b0;
      r0 = cyc;
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         if (!pll_rst) break;
         hi++;
         tick();
      end
      check("pll_rst_width", 32'(hi), 16);
      wait_cyc(r0 + 100);
      check("pre_lock_sys_rst", 32'(sys_rst), 1);
      locked = 1'b1;
      wait_release("powerup_release", 1027);

      // Lock glitch at STABLE count 500 restarts the filter.
      locked = 1'b0;
      do_reset();
      r0 = cyc;
      wait_cyc(r0 + 100);
      locked = 1'b1;
      l0 = cyc;
      wait_cyc(l0 + 503);
      locked = 1'b0;
      wait_cyc(l0 + 506);
      locked = 1'b1;
      l2 = cyc;
      wait_cyc(l0 + 1027);
      check("glitch_hold", 32'(sys_rst), 1);
      wait_release("glitch_release", 1027 - (cyc - l2));

      // Step request table.
      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].sel, vecs[i].dir, vecs[i].cnt);
         check($sformatf("v%0d_accept_ready", i), 32'(req_ready), 0);
         check($sformatf("v%0d_phasesel", i), 32'(phasesel), 32'(vecs[i].sel));
         check($sformatf("v%0d_phasedir", i), 32'(phasedir), 32'(vecs[i].dir));
         first_low = -1;
         lows = 0;
         dur = -1;
         for (int k = 1; k <= 120; k++) begin
            if (k == 3 && vecs[i].exp_dur >= 8) begin
               req_valid = 1'b1;
               req_sel   = 2'b00;
               req_dir   = 1'b0;
               req_count = 4'd15;
            end
            if (k == 4) req_valid = 1'b0;
            tick();
            if (!phasestep) begin
               lows++;
               if (first_low < 0) first_low = k;
            end
            if (k == 1 && vecs[i].cnt != 4'd0) check($sformatf("v%0d_busy", i), 32'(busy), 1);
            if (req_ready) begin
               dur = k;
               break;
            end
         end
         req_valid = 1'b0;
         if (vecs[i].cnt != 4'd0) check($sformatf("v%0d_first_low", i), 32'(first_low), 2);
         check($sformatf("v%0d_duration", i), 32'(dur), 32'(vecs[i].exp_dur));
         check($sformatf("v%0d_low_cycles", i), 32'(lows), 32'(vecs[i].exp_lows));
         check($sformatf("v%0d_phase_pos", i), 32'(phase_pos), 32'(vecs[i].exp_pos));
         check($sformatf("v%0d_sel_restore", i), 32'(phasesel), 0);
         check($sformatf("v%0d_dir_restore", i), 32'(phasedir), 1);
         check($sformatf("v%0d_busy_done", i), 32'(busy), 0);
      end

      // Synchronized lock drops during the 2nd low pulse of a 4-step request.
      issue(2'b00, 1'b0, 4'd4);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 7) locked = 1'b0;
         if (k == 9) begin
            check("loss_k9_phasestep", 32'(phasestep), 0);
            check("loss_k9_sys_rst", 32'(sys_rst), 0);
         end
      end
      check("loss_phasestep", 32'(phasestep), 1);
      check("loss_sys_rst", 32'(sys_rst), 1);
      check("loss_req_ready", 32'(req_ready), 0);
      check("loss_busy", 32'(busy), 1);
      check("loss_phase_pos", 32'(phase_pos), 13);
      check("loss_state", 32'(dut.state_q), 1);
      repeat (20) tick();
      check("loss_hold_state", 32'(dut.state_q), 1);
      check("loss_no_pll_rst", 32'(pll_rst), 0);
      locked = 1'b1;
      wait_release("relock_release", 1027);
      check("relock_phase_pos", 32'(phase_pos), 13);

      // rst mid-step overrides everything on the next edge.
      issue(2'b00, 1'b0, 4'd2);
      repeat (3) tick();
      check("midstep_low", 32'(phasestep), 0);
      rst = 1'b1;
      tick();
      check("midstep_rst_phasestep", 32'(phasestep), 1);
      check("midstep_rst_pll_rst", 32'(pll_rst), 1);
      check("midstep_rst_sys_rst", 32'(sys_rst), 1);
      check("midstep_rst_phase_pos", 32'(phase_pos), 0);
      check("midstep_rst_req_ready", 32'(req_ready), 0);
      check("midstep_rst_phasesel", 32'(phasesel), 0);
      check("midstep_rst_phasedir", 32'(phasedir), 1);

      // Lock never arrives: timeout instance re-pulses pll_rst only when the macro is set.
      locked = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      hi = 0;
      hi_to = 0;
      rises = 0;
      rises_to = 0;
      first_rise = -1;
      prev_to = pll_rst_to;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) tick();
         if (pll_rst) hi++;
         if (pll_rst_to) hi_to++;
         if (pll_rst_to && !prev_to) begin
            rises_to++;
            if (first_rise < 0) first_rise = k;
         end
         prev_to = pll_rst_to;
      end
      rises = (hi == 16 && !pll_rst) ? 0 : 1;
      check("no_lock_main_pll_rst_high", 32'(hi), 16);
      check("no_lock_main_single_pulse", 32'(rises), 0);
`ifdef PLL_PHASE_CTRL_LOCK_TIMEOUT_EN
      check("timeout_high_cycles", 32'(hi_to), 80);
      check("timeout_repulses", 32'(rises_to), 4);
      check("timeout_period", 32'(first_rise), 80);
`else
      check("timeout_high_cycles", 32'(hi_to), 16);
      check("timeout_repulses", 32'(rises_to), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
